// File: rtl/seg7_scan_driver_if.sv
// rtl/seg7_scan_driver_if.sv - value-load bundle between a host and the 7-segment scan driver
//
// Signals:
//   value  4*DIGITS  hex value to display; nibble i shows on digit i (digit 0 = least significant)
//   load   1         one-cycle strobe that captures value into the pending buffer
//   upd    1         one-cycle pulse from the driver: its display register was just updated
//
// Modports:
//   master  host side: drives value/load, observes upd
//   slave   driver side: receives value/load, drives upd

interface seg7_scan_driver_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] value;
    logic                load;
    logic                upd;

    modport master (
        output value,
        output load,
        input  upd
    );

    modport slave (
        input  value,
        input  load,
        output upd
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed, double-buffered seven-segment display driver
//
// Parameters:
//   DIGITS          number of digits scanned (1..8)
//   CLK_DIV         clock cycles each digit is driven (>= 2)
//   SEG_ACTIVE_LOW  1: a lit segment drives 0
//   SEL_ACTIVE_LOW  1: the selected digit drives 0 on its led_select_o bit
//
// Ports:
//   clk_i         system clock, single domain
//   reset_i       synchronous, active-low reset
//   enable_i      1: scan runs; 0: display dark, scan position held
//   blank_lz_i    1: suppress leading zero digits (digit 0 is always shown)
//   bus           slave side of seg7_scan_driver_if (value/load in, upd out)
//   led_o         segments {g,f,e,d,c,b,a}, registered
//   led_select_o  digit enables, one-hot when active, registered

module seg7_scan_driver #(
    parameter int DIGITS         = 4,
    parameter int CLK_DIV        = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                enable_i,
    input  logic                blank_lz_i,
    seg7_scan_driver_if.slave   bus,
    output logic [6:0]          led_o,
    output logic [DIGITS-1:0]   led_select_o
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(CLK_DIV);
    localparam int VAL_W = 4 * DIGITS;

    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CLK_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [6:0]        SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [DIGITS-1:0] SEL_OFF  = SEL_ACTIVE_LOW ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

    // Hex font, active-high, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h3F;
            4'h1:    seg = 7'h06;
            4'h2:    seg = 7'h5B;
            4'h3:    seg = 7'h4F;
            4'h4:    seg = 7'h66;
            4'h5:    seg = 7'h6D;
            4'h6:    seg = 7'h7D;
            4'h7:    seg = 7'h07;
            4'h8:    seg = 7'h7F;
            4'h9:    seg = 7'h6F;
            4'hA:    seg = 7'h77;
            4'hB:    seg = 7'h7C;
            4'hC:    seg = 7'h39;
            4'hD:    seg = 7'h5E;
            4'hE:    seg = 7'h79;
            default: seg = 7'h71;
        endcase
        return seg;
    endfunction

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [IDX_W-1:0]  idx_q,  idx_d;
    logic [VAL_W-1:0]  disp_q, disp_d;
    logic [VAL_W-1:0]  pend_q, pend_d;
    logic              pv_q,   pv_d;
    logic              upd_q,  upd_d;
    logic [6:0]        led_q,  led_d;
    logic [DIGITS-1:0] sel_q,  sel_d;

    logic              last_cnt;
    logic              frame_end;
    logic              xfer_slot;

    // Scan position: dwell counter and digit index advance only while enabled,
    // so disabling freezes the scan mid-digit and re-enabling finishes the dwell.
    always_comb begin
        last_cnt  = (cnt_q == CNT_LAST);
        frame_end = enable_i && last_cnt && (idx_q == IDX_LAST);
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        if (enable_i) begin
            if (last_cnt) begin
                cnt_d = '0;
                idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // Double buffer. The display register only changes on the last cycle of a
    // frame (so a frame never mixes two values) or at any time while dark.
    // A load landing on a transfer slot bypasses the pending buffer.
    always_comb begin
        xfer_slot = !enable_i || frame_end;
        disp_d    = disp_q;
        pend_d    = pend_q;
        pv_d      = pv_q;
        upd_d     = 1'b0;
        if (xfer_slot && bus.load) begin
            disp_d = bus.value;
            pend_d = bus.value;
            pv_d   = 1'b0;
            upd_d  = 1'b1;
        end else if (xfer_slot && pv_q) begin
            disp_d = pend_q;
            pv_d   = 1'b0;
            upd_d  = 1'b1;
        end else if (bus.load) begin
            pend_d = bus.value;
            pv_d   = 1'b1;
        end
    end

    // Output decode from the current digit index and display register.
    // nz_from[i] is set when any nibble from i up to the top is non-zero;
    // a digit with nz_from clear is a leading zero.
    logic [DIGITS-1:0] nz_from;
    logic              nz_acc;
    logic [3:0]        cur_nib;
    logic              cur_blank;
    logic [DIGITS-1:0] sel_hot;
    logic [6:0]        seg_on;

    always_comb begin
        nz_acc = 1'b0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nz_acc     = nz_acc | (disp_q[4*i +: 4] != 4'h0);
            nz_from[i] = nz_acc;
        end

        cur_nib   = 4'h0;
        cur_blank = 1'b0;
        sel_hot   = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib    = disp_q[4*i +: 4];
                cur_blank  = blank_lz_i && (i != 0) && !nz_from[i];
                sel_hot[i] = 1'b1;
            end
        end

        seg_on = cur_blank ? 7'h00 : font(cur_nib);

        if (enable_i) begin
            led_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
            sel_d = SEL_ACTIVE_LOW ? ~sel_hot : sel_hot;
        end else begin
            led_d = SEG_OFF;
            sel_d = SEL_OFF;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            disp_q <= '0;
            pend_q <= '0;
            pv_q   <= 1'b0;
            upd_q  <= 1'b0;
            led_q  <= SEG_OFF;
            sel_q  <= SEL_OFF;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            disp_q <= disp_d;
            pend_q <= pend_d;
            pv_q   <= pv_d;
            upd_q  <= upd_d;
            led_q  <= led_d;
            sel_q  <= sel_d;
        end
    end

    assign bus.upd      = upd_q;
    assign led_o        = led_q;
    assign led_select_o = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb/tb_seg7_scan_driver.sv - self-checking bench for seg7_scan_driver (default and 8-digit active-high builds)

module tb_seg7_scan_driver;

    localparam logic [6:0] FONT [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                         7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    typedef struct {
        int          pos;
        logic [31:0] disp;
        logic [31:0] pend;
        logic        pv;
        logic        upd;
        logic [6:0]  led;
        logic [7:0]  sel;
    } mstate_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en_a, blz_a, en_b, blz_b;
    logic [6:0] led_a, led_b;
    logic [3:0] sel_a;
    logic [7:0] sel_b;

    int      n_checks = 0;
    int      n_errors = 0;
    int      ecount = 0;
    bit      started = 1'b0;
    bit      a_done = 1'b0;
    mstate_t ma, mb;

    seg7_scan_driver_if #(.DIGITS(4)) bus_a ();
    seg7_scan_driver_if #(.DIGITS(8)) bus_b ();

    seg7_scan_driver #(.DIGITS(4), .CLK_DIV(16), .SEG_ACTIVE_LOW(1'b1), .SEL_ACTIVE_LOW(1'b1)) dut_a (
        .clk_i(clk), .reset_i(rst_n), .enable_i(en_a), .blank_lz_i(blz_a),
        .bus(bus_a), .led_o(led_a), .led_select_o(sel_a)
    );

    seg7_scan_driver #(.DIGITS(8), .CLK_DIV(2), .SEG_ACTIVE_LOW(1'b0), .SEL_ACTIVE_LOW(1'b0)) dut_b (
        .clk_i(clk), .reset_i(rst_n), .enable_i(en_b), .blank_lz_i(blz_b),
        .bus(bus_b), .led_o(led_b), .led_select_o(sel_b)
    );

    always #5 clk = ~clk;

    // Scan position is kept as a single frame-relative cycle number.
    function automatic mstate_t step(mstate_t s, int digits, int cdiv, bit seg_al, bit sel_al,
                                     bit rn, bit en, bit ld, logic [31:0] val, bit blz);
        mstate_t     n;
        int          dig;
        logic [31:0] upper, vmask;
        logic [6:0]  seg;
        logic [7:0]  sel, selmask;
        n       = s;
        selmask = 8'((1 << digits) - 1);
        vmask   = (digits == 8) ? 32'hFFFF_FFFF : ((32'd1 << (4 * digits)) - 32'd1);
        if (!rn) begin
            n.pos = 0; n.disp = 0; n.pend = 0; n.pv = 0; n.upd = 0;
            n.led = seg_al ? 7'h7F : 7'h00;
            n.sel = sel_al ? selmask : 8'h00;
            return n;
        end
        dig   = s.pos / cdiv;
        upper = s.disp >> (4 * dig);
        seg   = 7'h00;
        sel   = 8'h00;
        if (en) begin
            sel = 8'(1 << dig);
            if (!(blz && dig > 0 && upper == 0)) seg = FONT[upper[3:0]];
        end
        n.led = seg_al ? ~seg : seg;
        n.sel = sel_al ? (~sel & selmask) : sel;
        n.upd = 1'b0;
        if (!en || s.pos == digits * cdiv - 1) begin
            if (ld) begin
                n.disp = val & vmask; n.pv = 0; n.upd = 1;
            end else if (s.pv) begin
                n.disp = s.pend; n.pv = 0; n.upd = 1;
            end
        end else if (ld) begin
            n.pend = val & vmask; n.pv = 1;
        end
        if (en) n.pos = (s.pos + 1) % (digits * cdiv);
        return n;
    endfunction

    always @(posedge clk) begin
        ma <= step(ma, 4, 16, 1'b1, 1'b1, rst_n, en_a, bus_a.load, 32'(bus_a.value), blz_a);
        mb <= step(mb, 8, 2, 1'b0, 1'b0, rst_n, en_b, bus_b.load, bus_b.value, blz_b);
        ecount <= rst_n ? ecount + 1 : 0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            check("a_led", 32'(led_a), 32'(ma.led));
            check("a_sel", 32'(sel_a), 32'(ma.sel[3:0]));
            check("a_upd", 32'(bus_a.upd), 32'(ma.upd));
            check("b_led", 32'(led_b), 32'(mb.led));
            check("b_sel", 32'(sel_b), 32'(mb.sel));
            check("b_upd", 32'(bus_b.upd), 32'(mb.upd));
        end
    end

    task automatic wait_e(input int n);
        while (ecount < n) @(negedge clk);
    endtask

    task automatic load_a(input logic [15:0] v, input int e);
        wait_e(e);
        bus_a.value = v;
        bus_a.load  = 1'b1;
        wait_e(e + 1);
        bus_a.load  = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        en_a = 1'b1; blz_a = 1'b0; en_b = 1'b1; blz_b = 1'b0;
        bus_a.load = 1'b0; bus_a.value = '0;
        bus_b.load = 1'b0; bus_b.value = '0;
        repeat (3) @(posedge clk);
        #1 started = 1'b1;
        @(negedge clk);
        check("rst_a_led", 32'(led_a), 32'h7F);
        check("rst_a_sel", 32'(sel_a), 32'hF);
        check("rst_a_upd", 32'(bus_a.upd), 32'h0);
        check("rst_b_led", 32'(led_b), 32'h00);
        check("rst_b_sel", 32'(sel_b), 32'h00);
        rst_n = 1'b1;

        fork
            begin
                wait_e(1);
                check("first_led", 32'(led_a), 32'h40);
                check("first_sel", 32'(sel_a), 32'hE);
                wait_e(17);  check("dig1_sel", 32'(sel_a), 32'hD);
                wait_e(65);  check("wrap_sel", 32'(sel_a), 32'hE);
                load_a(16'h1234, 81);
                wait_e(96);  check("no_tear_led", 32'(led_a), 32'h40);
                wait_e(128); check("xfer_upd", 32'(bus_a.upd), 32'h1);
                             check("xfer_old_led", 32'(led_a), 32'h40);
                wait_e(129); check("new_d0_led", 32'(led_a), 32'h19);
                             check("upd_one_cycle", 32'(bus_a.upd), 32'h0);
                wait_e(145); check("new_d1_led", 32'(led_a), 32'h30);
                load_a(16'hAAAA, 150);
                load_a(16'h5678, 160);
                wait_e(192); check("lastwin_upd", 32'(bus_a.upd), 32'h1);
                wait_e(193); check("lastwin_led", 32'(led_a), 32'h00);
                blz_a = 1'b1;
                load_a(16'h0050, 255);
                wait_e(256); check("coinc_upd", 32'(bus_a.upd), 32'h1);
                wait_e(257); check("lz_d0", 32'(led_a), 32'h40);
                wait_e(273); check("lz_d1", 32'(led_a), 32'h12);
                wait_e(289); check("lz_d2", 32'(led_a), 32'h7F);
                wait_e(305); check("lz_d3", 32'(led_a), 32'h7F);
                             check("lz_d3_sel", 32'(sel_a), 32'h7);
                wait_e(320); check("coinc_no_pv", 32'(bus_a.upd), 32'h0);
                load_a(16'h0000, 330);
                wait_e(385); check("zero_d0", 32'(led_a), 32'h40);
                wait_e(401); check("zero_d1", 32'(led_a), 32'h7F);
                load_a(16'h4321, 410);
                wait_e(485);
                en_a = 1'b0;
                bus_a.value = 16'h9ABC;
                bus_a.load  = 1'b1;
                wait_e(486); check("dark_sel", 32'(sel_a), 32'hF);
                             check("dark_led", 32'(led_a), 32'h7F);
                             check("dark_upd", 32'(bus_a.upd), 32'h1);
                bus_a.load = 1'b0;
                wait_e(489); en_a = 1'b1;
                wait_e(490); check("resume_sel", 32'(sel_a), 32'hB);
                             check("resume_led", 32'(led_a), 32'h08);
                wait_e(500); check("dwell_end_sel", 32'(sel_a), 32'hB);
                wait_e(501); check("after_dwell_sel", 32'(sel_a), 32'h7);
                             check("after_dwell_led", 32'(led_a), 32'h10);
                load_a(16'h7777, 510);
                wait_e(520);
                rst_n = 1'b0;
                @(negedge clk);
                check("midrst_led", 32'(led_a), 32'h7F);
                check("midrst_upd", 32'(bus_a.upd), 32'h0);
                rst_n = 1'b1;
                wait_e(1);  check("postrst_led", 32'(led_a), 32'h40);
                wait_e(64); check("postrst_upd", 32'(bus_a.upd), 32'h0);
                wait_e(65); check("pend_lost_led", 32'(led_a), 32'h40);
                a_done = 1'b1;
            end
            begin
                wait_e(3);
                bus_b.value = 32'hFEDC_BA98;
                bus_b.load  = 1'b1;
                wait_e(4);  bus_b.load = 1'b0;
                wait_e(16); check("b_upd_lit", 32'(bus_b.upd), 32'h1);
                wait_e(17); check("b_d0_led", 32'(led_b), 32'h7F);
                            check("b_d0_sel", 32'(sel_b), 32'h01);
                wait_e(19); check("b_d1_sel", 32'(sel_b), 32'h02);
                wait_e(31); check("b_d7_led", 32'(led_b), 32'h71);
                            check("b_d7_sel", 32'(sel_b), 32'h80);
                wait_e(33); check("b_frame_sel", 32'(sel_b), 32'h01);
                while (!a_done) begin
                    @(negedge clk);
                    en_b        = ($urandom_range(0, 7) != 0);
                    blz_b       = 1'($urandom_range(0, 1));
                    bus_b.load  = ($urandom_range(0, 5) == 0);
                    bus_b.value = $urandom >> (4 * $urandom_range(0, 7));
                end
            end
        join

        for (int c = 0; c < 2500; c++) begin
            @(negedge clk);
            rst_n       = ($urandom_range(0, 299) != 0);
            en_a        = ($urandom_range(0, 7) != 0);
            blz_a       = 1'($urandom_range(0, 1));
            bus_a.load  = ($urandom_range(0, 9) == 0);
            bus_a.value = 16'($urandom >> (4 * $urandom_range(0, 4)));
            en_b        = ($urandom_range(0, 7) != 0);
            blz_b       = 1'($urandom_range(0, 1));
            bus_b.load  = ($urandom_range(0, 5) == 0);
            bus_b.value = $urandom >> (4 * $urandom_range(0, 7));
        end
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed seven-segment display driver that produces the `led`/`led_select` pair at the top level of the MIPS board design. Adds four things to a fixed 4-digit hex scan:
- configurable digit count and dwell time;
- selectable output polarity;
- leading-zero blanking;
- a tear-free double-buffered value update with a one-cycle acknowledge pulse.

The CPU or debug logic writes a value with `load`; the block presents that value starting at the next frame boundary.

## Interface
Parameters:
- DIGITS, 4, number of digits scanned (1..8)
- CLK_DIV, 16, clock cycles each digit is driven (dwell), ≥2
- SEG_ACTIVE_LOW, 1, 1: a lit segment drives 0; 0: a lit segment drives 1
- SEL_ACTIVE_LOW, 1, 1: the selected digit drives 0 on its `led_select` bit

Ports:
- clk  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-low reset
- enable  in  1  1: scan runs; 0: display dark, scan counters hold
- value  in  4*DIGITS  hex value to display; nibble i shows on digit i (digit 0 = least significant)
- load  in  1  1-cycle strobe; captures `value` into the pending buffer
- blank_lz  in  1  1: suppress leading zero digits
- led  out  7  segments {g,f,e,d,c,b,a}
- led_select  out  DIGITS  digit enables, one-hot when active
- upd  out  1  1-cycle pulse; the display register was just updated

## Operation
- State:
  - dwell counter `cnt` (0..CLK_DIV-1)
  - digit index `idx` (0..DIGITS-1)
  - display register `disp`
  - pending register `pend` with flag `pv`
- Scan:
  - While enable=1, `cnt` increments every cycle.
  - When `cnt`=CLK_DIV-1, `cnt` wraps to 0 and `idx` advances.
  - After DIGITS-1, `idx` wraps to 0.
- Frame boundary: the cycle in which `cnt`=CLK_DIV-1 and `idx`=DIGITS-1, with enable=1.
- Loading and transfer:
  - `load`=1 writes `value` to `pend` and sets `pv`. If several loads arrive before a transfer, the last one wins.
  - At a frame boundary with `pv`=1: `disp` ← `pend`, `pv` cleared, `upd`=1 on the next cycle.
  - If `load` coincides with a frame boundary, `value` goes directly to `disp`, `pv` ends at 0, and `upd` pulses.
  - While enable=0, a pending or concurrent load transfers on the next edge; tearing is not a concern while the display is dark.
- Font (active-high codes, inverted when SEG_ACTIVE_LOW=1):
  - 0:3F 1:06 2:5B 3:4F
  - 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C
  - C:39 d:5E E:79 F:71
- Leading-zero blanking:
  - With blank_lz=1, digit i is blanked (all segments off) when nibbles i..DIGITS-1 of `disp` are all zero and i>0.
  - Digit 0 is never blanked.
  - `led_select` still scans blanked digits.
- Dark state (enable=0):
  - all `led_select` bits inactive, `led` all-off;
  - `cnt`/`idx` hold.
  - When enable returns to 1, scanning resumes from the held position.

## Timing
- Output registers: `led`, `led_select`, `upd` are registered.
  - The outputs visible after edge k reflect `idx`/`disp`/blank_lz as they stood before edge k.
  - Latency from state to pins is 1 cycle.
- Reset (reset=0 at an edge):
  - `cnt`=0, `idx`=0, `disp`=0, `pend`=0, `pv`=0, `upd`=0;
  - `led`=all-off (7'h7F if SEG_ACTIVE_LOW, else 7'h00);
  - `led_select` all inactive.
- Reset mid-frame discards any pending value and emits no `upd` pulse.
- After reset releases: first edge with reset=1 and enable=1 drives digit 0 with `disp`=0, i.e. "0" (3F active-high).
- Each digit is active for exactly CLK_DIV consecutive cycles; a full frame is DIGITS*CLK_DIV cycles.
- Digit changes are glitch-free: `led` and `led_select` update on the same edge.
- `upd` is high for exactly 1 cycle per transfer, 1 cycle after the boundary or enable=0 transfer edge.
- `load` while `upd`=1 is legal and is handled as a new pending write.

## Test plan
- Reset with defaults (DIGITS=4, CLK_DIV=16, active-low):
  - After release: `led`=7'h40 ("0"), `led_select`=4'b1110.
  - After 16 cycles: `led_select`=4'b1101.
  - After 64 cycles, the sequence is back to 4'b1110.
- Double-buffer, no tearing: load 16'h1234 while digit 1 is active.
  - The digits keep showing 0 until the frame boundary.
  - `upd` pulses once.
  - The next frame shows 4,3,2,1 on digits 0..3 (codes 66,4F,5B,06 inverted).
- Last load wins, and boundary coincidence:
  - Load A then B before the boundary: only B is displayed, one `upd`.
  - Load C exactly at the boundary: C is displayed in the very next frame, `pv`=0.
- Leading-zero blanking: `disp`=16'h0050, blank_lz=1.
  - Digits 3 and 2 are all-off (7'h7F).
  - Digit 1 shows "5", digit 0 shows "0".
  - `disp`=0 shows only digit 0 as "0".
- Enable and mid-frame reset:
  - enable=0 mid-digit-2: `led_select`=4'b1111, and the load transfers immediately.
  - Re-enable: digit 2 completes its remaining dwell.
  - reset=0 mid-frame with `pv`=1: the pending value is lost and no `upd` pulse is emitted.
- Parameter sweep, DIGITS=8, CLK_DIV=2, SEG_ACTIVE_LOW=0, SEL_ACTIVE_LOW=0:
  - Load 32'hFEDCBA98: one-hot `led_select` advances every 2 cycles.
  - Digit 7 shows 7'h71 ("F").
  - The frame is 16 cycles.
